// File: rtl/subtrator_serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package subtrator_serial_pkg;

   localparam int unsigned N_DEFAULT = 8;

   localparam logic [1:0] OCIOSO = 2'b00;
   localparam logic [1:0] CALC   = 2'b01;
   localparam logic [1:0] FIM    = 2'b10;

endpackage

// File: rtl/subtrator_completo.sv
// One-bit full subtractor cell: difference and borrow for ai - bi - bin.
module subtrator_completo (
   input  logic ai,
   input  logic bi,
   input  logic bin,
   output logic d_c,
   output logic bout_c
);

   // Difference bit and outgoing borrow
   always_comb begin
      d_c    = ai ^ bi ^ bin;
      bout_c = (~ai & bi) | (~(ai ^ bi) & bin);
   end

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor: computes a - b one bit per cycle, LSB first.
module subtrator_serial
   import subtrator_serial_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inicio,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         borrow_out,
   output logic         ocupado,
   output logic         pronto
);

   localparam int unsigned     CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

   logic [1:0]   state;
   logic [1:0]   state_next;
   logic         carregar_c;
   logic         calcular_c;
   logic         concluir_c;

   logic [N-1:0] a_sr;
   logic [N-1:0] b_sr;
   logic [N-1:0] r_sr;
   logic [N-1:0] r_next_c;
   logic [CW-1:0] cnt;
   logic         bin;
   logic         d_c;
   logic         bout_c;

   subtrator_completo u_celula (
      .ai     (a_sr[0]),
      .bi     (b_sr[0]),
      .bin    (bin),
      .d_c    (d_c),
      .bout_c (bout_c)
   );

   // New difference bit enters the result from the MSB end
   assign r_next_c = {d_c, r_sr[N-1:1]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= OCIOSO;
      else        state <= state_next;
   end

   // Next-state and datapath control; start requests only matter in OCIOSO
   always_comb begin
      state_next = state;
      carregar_c = 1'b0;
      calcular_c = 1'b0;
      concluir_c = 1'b0;
      case (state)
         OCIOSO: begin
            if (inicio) begin
               state_next = CALC;
               carregar_c = 1'b1;
            end
         end
         CALC: begin
            calcular_c = 1'b1;
            if (cnt == CNT_LAST) begin
               state_next = FIM;
               concluir_c = 1'b1;
            end
         end
         FIM:     state_next = OCIOSO;
         default: state_next = OCIOSO;
      endcase
   end

   // Operand/result shift registers, borrow chain, bit counter and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr       <= '0;
         b_sr       <= '0;
         r_sr       <= '0;
         bin        <= 1'b0;
         cnt        <= '0;
         s          <= '0;
         borrow_out <= 1'b0;
      end else begin
         if (carregar_c) begin
            a_sr <= a;
            b_sr <= b;
            bin  <= 1'b0;
            cnt  <= '0;
         end
         if (calcular_c) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_next_c;
            bin  <= bout_c;
            if (!concluir_c) cnt <= cnt + CW'(1);
         end
         if (concluir_c) begin
            s          <= r_next_c;
            borrow_out <= bout_c;
         end
      end
   end

   // Status flags registered from the upcoming state so they track the state exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ocupado <= 1'b0;
         pronto  <= 1'b0;
      end else begin
         ocupado <= (state_next != OCIOSO);
         pronto  <= (state_next == FIM);
      end
   end

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (N=8).
module tb_subtrator_serial;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         inicio = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [N-1:0] s;
   logic         borrow_out;
   logic         ocupado;
   logic         pronto;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [N-1:0] va;
      logic [N-1:0] vb;
      logic [N-1:0] es;
      logic         eb;
   } vec_t;

   vec_t tab [6];

   subtrator_serial #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inicio     (inicio),
      .a          (a),
      .b          (b),
      .s          (s),
      .borrow_out (borrow_out),
      .ocupado    (ocupado),
      .pronto     (pronto)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", nome, got, exp);
      end
   endtask

   // Start one operation from idle and check latency, hold behaviour and result
   task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                         input logic [N-1:0] es, input logic eb, input string nome);
      int           j;
      logic [N-1:0] s_prev;
      bit           hold_ok;
      j = 0;
      while (ocupado && j < 30) begin @(negedge clk); j++; end
      chk({nome, "_idle"}, 32'(ocupado), 32'd0);
      s_prev = s;
      a = va; b = vb; inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      chk({nome, "_busy"}, 32'(ocupado), 32'd1);
      j = 0; hold_ok = 1'b1;
      do begin
         @(negedge clk);
         j++;
         if (!pronto && s !== s_prev) hold_ok = 1'b0;
      end while (!pronto && j < 20);
      chk({nome, "_latency"}, 32'(j), 32'(N));
      chk({nome, "_s"}, 32'(s), 32'(es));
      chk({nome, "_borrow"}, 32'(borrow_out), 32'(eb));
      chk({nome, "_hold"}, 32'(hold_ok), 32'd1);
      @(negedge clk);
      chk({nome, "_pulse1"}, 32'(pronto), 32'd0);
      chk({nome, "_idle_after"}, 32'(ocupado), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int           cnt_p;
      logic [N-1:0] s_cap;
      logic         bo_cap;
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic [N-1:0] ms;

      tab[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
      tab[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
      tab[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
      tab[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      tab[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
      tab[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};

      // Reset state
      #3;
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_borrow", 32'(borrow_out), 32'd0);
      chk("rst_ocupado", 32'(ocupado), 32'd0);
      chk("rst_pronto", 32'(pronto), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 6; i++)
         run_op(tab[i].va, tab[i].vb, tab[i].es, tab[i].eb, $sformatf("tab%0d", i));

      // Start ignored during CALC, operand changes after acceptance ignored
      a = 8'h10; b = 8'h01; inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a = 8'hAA; b = 8'h55; inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      cnt_p = 0; s_cap = '0; bo_cap = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (pronto) begin cnt_p++; s_cap = s; bo_cap = borrow_out; end
      end
      chk("ignore_pronto_count", 32'(cnt_p), 32'd1);
      chk("ignore_s", 32'(s_cap), 32'h0F);
      chk("ignore_borrow", 32'(bo_cap), 32'd0);

      // Asynchronous reset in the middle of CALC
      run_op(8'h05, 8'h03, 8'h02, 1'b0, "pre_rst");
      a = 8'h33; b = 8'h11; inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_s", 32'(s), 32'd0);
      chk("arst_borrow", 32'(borrow_out), 32'd0);
      chk("arst_ocupado", 32'(ocupado), 32'd0);
      chk("arst_pronto", 32'(pronto), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt_p = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (pronto) cnt_p++;
      end
      chk("arst_no_pronto", 32'(cnt_p), 32'd0);
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, "post_rst");

      // inicio held high: a new operation every N+2 cycles
      a = 8'h37; b = 8'h12; inicio = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 39) inicio = 1'b0;
         chk($sformatf("b2b_pronto_%0d", i), 32'(pronto), 32'((i % 10) == 8));
         chk($sformatf("b2b_ocupado_%0d", i), 32'(ocupado), 32'((i % 10) != 9));
         if (pronto) chk($sformatf("b2b_s_%0d", i), 32'(s), 32'h25);
      end
      @(negedge clk);

      // Random operands against arithmetic reference
      for (int i = 0; i < 30; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         ms = ra - rb;
         run_op(ra, rb, ms, (ra < rb), $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/subtrator_serial.md
SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N SHALL default to 8 and sets the operand width (legal N >= 2).
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 inicio  input  1  start request, sampled on the rising edge of clk.
REQ-006 a  input  N  minuend, sampled when a start is accepted.
REQ-007 b  input  N  subtrahend, sampled when a start is accepted.
REQ-008 s  output  N  registered difference (a - b) mod 2^N.
REQ-009 borrow_out  output  1  registered final borrow; 1 means a < b (unsigned).
REQ-010 ocupado  output  1  busy; high whenever state is not OCIOSO.
REQ-011 pronto  output  1  done; a one-cycle pulse when s and borrow_out update.

Function
REQ-012 The FSM SHALL have the states OCIOSO, CALC and FIM.
REQ-013 OCIOSO with inicio=1 at an edge SHALL load a and b into shift registers, clear the internal borrow and the bit counter, and go to CALC.
REQ-014 OCIOSO with inicio=0 SHALL stay in OCIOSO.
REQ-015 CALC SHALL process exactly one bit per cycle, LSB first, using a 1-bit full subtractor: d = ai^bi^bin; bout = (~ai&bi) | (~(ai^bi)&bin).
REQ-016 In CALC, each d SHALL shift into the result shift register from the MSB end, and bout SHALL become bin for the next bit.
REQ-017 The bit counter SHALL be ceil(log2(N)) bits wide and SHALL count 0..N-1 without wrap-around.
REQ-018 At the edge that processes bit N-1, the FSM SHALL go to FIM, and s and borrow_out SHALL load the full result and the final bout.
REQ-019 pronto SHALL be high only while the state is FIM, so it is exactly one cycle long.
REQ-020 FIM SHALL go unconditionally to OCIOSO on the next edge.
REQ-021 Latency: for inicio accepted at edge E0, pronto SHALL be high in the cycle following edge E0+N; the next start is accepted no earlier than edge E0+N+2.
REQ-022 inicio SHALL be ignored in CALC and FIM: no reload and no restart.
REQ-023 Changes on a and b after acceptance SHALL NOT affect the running operation.
REQ-024 s and borrow_out SHALL hold their previous values during CALC and SHALL change only at the completion edge (REQ-018).
REQ-025 Back-to-back starts: inicio held high continuously SHALL start a new operation every N+2 cycles.

Reset
REQ-026 rst_n=0 SHALL force immediately, regardless of clk: state OCIOSO, counter 0, internal borrow 0, shift registers 0, s=0, borrow_out=0, pronto=0, ocupado=0.
REQ-027 Reset during CALC SHALL abort the operation with no pronto pulse.
REQ-028 The first start after rst_n returns high SHALL behave exactly as from power-up.

Structure
REQ-029 A shared package SHALL hold the state encoding constants (OCIOSO=2'b00, CALC=2'b01, FIM=2'b10) and the default width N.
REQ-030 The 1-bit full-subtractor cell SHALL be a separate combinational sub-module named subtrator_completo, instantiated once; all sequencing SHALL be in subtrator_serial.

Verification (N=8)
REQ-031 Scenario: a=0x05, b=0x03, inicio pulse -> pronto exactly 8 edges after acceptance, s=0x02, borrow_out=0.
REQ-032 Scenario: a=0x03, b=0x05 -> s=0xFE, borrow_out=1; a=0x00, b=0xFF -> s=0x01, borrow_out=1.
REQ-033 Scenario: a=0xFF, b=0xFF -> s=0x00, borrow_out=0; a=0xFF, b=0x00 -> s=0xFF, borrow_out=0.
REQ-034 Scenario: start with a=0x10, b=0x01, then pulse inicio and change a and b to 0xAA/0x55 at cycle 3 -> one pronto only, s=0x0F, borrow_out=0.
REQ-035 Scenario: rst_n=0 at cycle 4 of CALC (previous s=0x02) -> outputs 0 asynchronously, no pronto; then start a=0x80, b=0x01 -> s=0x7F, borrow_out=0.
REQ-036 Scenario: inicio held high for 40 cycles with fixed operands -> pronto pulses every 10 cycles, ocupado low for one cycle between operations.
